// File: rtl/n4_b10_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : n4_b10_stopwatch_ctrl                                           |
// | Purpose  : start/stop/clear stopwatch sequencer for a 4-digit BCD counter; |
// |            prescales m_clock into count ticks and saturates at 9999.       |
// | Options  : STOPWATCH_LAP_EN adds a lap hold register in front of disp.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module n4_b10_stopwatch_ctrl #(
    parameter int PRESCALE = 10,
    parameter int PS_W     = 16
) (
    input  logic        m_clock,
    input  logic        m_reset_,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    input  logic [15:0] cnt_q,
    output logic        cnt_ei,
    output logic        cnt_clr,
    output logic [15:0] disp,
    output logic        running,
    output logic        ovf
);

    localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] C_PS_ONE  = PS_W'(1);
    localparam logic [15:0]     C_CNT_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } state_t;

    state_t          r_state;
    logic [PS_W-1:0] r_ps;
    logic            r_cnt_clr;
    logic            r_running;
    logic            r_ovf;

    logic            w_ps_last;
    logic            w_tick_due;
    logic            w_at_max;

    assign w_ps_last  = (r_ps == C_PS_LAST);
    assign w_tick_due = (r_state == ST_RUN) && w_ps_last;
    assign w_at_max   = (cnt_q == C_CNT_MAX);

    // A tick landing on 9999 is swallowed so the counter never wraps.
    assign cnt_ei  = w_tick_due && !w_at_max;
    assign cnt_clr = r_cnt_clr;
    assign running = r_running;
    assign ovf     = r_ovf;

    always_ff @(posedge m_clock or negedge m_reset_) begin
        if (!m_reset_) begin
            r_state   <= ST_IDLE;
            r_ps      <= '0;
            r_cnt_clr <= 1'b0;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_cnt_clr <= 1'b0;
            if (clear) begin
                r_state   <= ST_IDLE;
                r_ps      <= '0;
                r_cnt_clr <= 1'b1;
                r_running <= 1'b0;
                r_ovf     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_stop) begin
                            r_state   <= ST_RUN;
                            r_ps      <= '0;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Prescaler advances even on the pausing edge so a tick issued there is not repeated on resume.
                        r_ps <= w_ps_last ? '0 : r_ps + C_PS_ONE;
                        if (w_tick_due && w_at_max) begin
                            r_state   <= ST_OVF;
                            r_running <= 1'b0;
                            r_ovf     <= 1'b1;
                        end else if (start_stop) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_stop) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_OVF: begin
                        r_state <= ST_OVF;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_ps      <= '0;
                        r_running <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [15:0] r_hold;
    logic        r_lap_valid;
    logic        w_lap_ok;

    assign w_lap_ok = (r_state == ST_RUN) || (r_state == ST_PAUSE);

    always_ff @(posedge m_clock or negedge m_reset_) begin
        if (!m_reset_) begin
            r_hold      <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_valid <= 1'b0;
        end else if (lap && w_lap_ok) begin
            if (r_lap_valid) begin
                r_lap_valid <= 1'b0;
            end else begin
                r_hold      <= cnt_q;
                r_lap_valid <= 1'b1;
            end
        end
    end

    assign disp = r_lap_valid ? r_hold : cnt_q;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign disp         = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_n4_b10_stopwatch_ctrl.sv
`default_nettype none
// Testbench for n4_b10_stopwatch_ctrl: directed scenarios then random traffic,
// every cycle checked against a behavioural stopwatch model with an emulated BCD counter.
module tb_n4_b10_stopwatch_ctrl;

    localparam int P = 10;

    logic        m_clock;
    logic        m_reset_;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] cnt_q;
    logic        cnt_ei;
    logic        cnt_clr;
    logic [15:0] disp;
    logic        running;
    logic        ovf;

    n4_b10_stopwatch_ctrl #(
        .PRESCALE (P),
        .PS_W     (16)
    ) dut (
        .m_clock    (m_clock),
        .m_reset_   (m_reset_),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .cnt_q      (cnt_q),
        .cnt_ei     (cnt_ei),
        .cnt_clr    (cnt_clr),
        .disp       (disp),
        .running    (running),
        .ovf        (ovf)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model
    string       mode;
    int          run_cycles;
    bit          clr_pending;
    bit          lap_valid;
    logic [15:0] hold;
    logic [15:0] tb_cnt;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int n;
        n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]) + 1;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        mode        = "IDLE";
        run_cycles  = 0;
        clr_pending = 1'b0;
        lap_valid   = 1'b0;
        hold        = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp);
        bit          due;
        bit          exp_ei;
        logic [15:0] exp_disp;
        logic [15:0] q;
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        cnt_q      = tb_cnt;
        q          = tb_cnt;
        @(negedge m_clock);
        due    = (mode == "RUN") && ((run_cycles % P) == P - 1);
        exp_ei = due && (q != 16'h9999);
`ifdef STOPWATCH_LAP_EN
        exp_disp = lap_valid ? hold : q;
`else
        exp_disp = q;
`endif
        chk("running", {15'd0, running}, {15'd0, mode == "RUN"});
        chk("ovf",     {15'd0, ovf},     {15'd0, mode == "OVF"});
        chk("cnt_ei",  {15'd0, cnt_ei},  {15'd0, exp_ei});
        chk("cnt_clr", {15'd0, cnt_clr}, {15'd0, clr_pending});
        chk("disp",    disp,             exp_disp);
        @(posedge m_clock);
        if (clr_pending)  tb_cnt = 16'h0000;
        else if (exp_ei)  tb_cnt = bcd_inc(tb_cnt);
        clr_pending = clr;
        if (clr) begin
            mode       = "IDLE";
            run_cycles = 0;
            lap_valid  = 1'b0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (lp && (mode == "RUN" || mode == "PAUSE")) begin
                if (lap_valid) lap_valid = 1'b0;
                else begin
                    hold      = q;
                    lap_valid = 1'b1;
                end
            end
`endif
            if (mode == "IDLE") begin
                if (ss) begin
                    mode       = "RUN";
                    run_cycles = 0;
                end
            end else if (mode == "RUN") begin
                run_cycles++;
                if (due && q == 16'h9999) mode = "OVF";
                else if (ss)              mode = "PAUSE";
            end else if (mode == "PAUSE") begin
                if (ss) mode = "RUN";
            end
        end
        #1;
    endtask

    task automatic async_reset_pulse(input bit expect_clr_now);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        @(negedge m_clock);
        #2;
        if (expect_clr_now) chk("clr_before_rst", {15'd0, cnt_clr}, 16'd1);
        m_reset_ = 1'b0;
        #1;
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_ovf",     {15'd0, ovf},     16'd0);
        chk("rst_cnt_ei",  {15'd0, cnt_ei},  16'd0);
        chk("rst_cnt_clr", {15'd0, cnt_clr}, 16'd0);
        chk("rst_disp",    disp,             tb_cnt);
        @(posedge m_clock);
        #1;
        m_reset_ = 1'b1;
        model_reset();
    endtask

    initial begin
        m_reset_   = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        tb_cnt     = 16'h0000;
        cnt_q      = 16'h0000;
        model_reset();
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        chk("reset_running", {15'd0, running}, 16'd0);
        chk("reset_ovf",     {15'd0, ovf},     16'd0);
        chk("reset_cnt_ei",  {15'd0, cnt_ei},  16'd0);
        chk("reset_cnt_clr", {15'd0, cnt_clr}, 16'd0);
        chk("reset_disp",    disp,             16'h0000);
        @(posedge m_clock);
        #1;
        m_reset_ = 1'b1;

        // Start and count three ticks
        step(1, 0, 0);
        repeat (31) step(0, 0, 0);

        // Pause after 25 run cycles, hold for 50, resume
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (24) step(0, 0, 0);
        step(1, 0, 0);
        repeat (50) step(0, 0, 0);
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);

        // Saturation at 9999, start_stop ignored, clear exits
        step(0, 1, 0);
        step(1, 0, 0);
        tb_cnt = 16'h9999;
        repeat (12) step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);

        // clear and start_stop together while running
        step(1, 0, 0);
        repeat (7) step(0, 0, 0);
        step(1, 1, 0);
        repeat (12) step(0, 0, 0);

        // Lap capture and release
        step(1, 0, 0);
        tb_cnt = 16'h0123;
        step(0, 0, 1);
        repeat (25) step(0, 0, 0);
        step(0, 0, 1);
        repeat (5) step(0, 0, 0);

        // Asynchronous reset mid-run, then during a pending clear pulse
        repeat (6) step(0, 0, 0);
        async_reset_pulse(1'b0);
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        repeat (4) step(0, 0, 0);
        step(0, 1, 0);
        async_reset_pulse(1'b1);
        repeat (2) step(0, 0, 0);

        // Non-BCD value passes straight to the display in IDLE
        tb_cnt = 16'hABCD;
        repeat (3) step(0, 0, 0);
        tb_cnt = 16'h0000;

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) tb_cnt = 16'h9990 | 16'($urandom_range(0, 9));
            step($urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
